// File: rtl/pdm_mic_decimator_if.sv
// PCM sample handshake between the PDM decimator (master) and its consumer (slave).
interface pdm_mic_decimator_if #(
   parameter int OW = 10
) ();
   logic [OW-1:0] pcm_data;
   logic          pcm_valid;
   logic          pcm_ready;

   modport master (output pcm_data, output pcm_valid, input pcm_ready);
   modport slave  (input pcm_data, input pcm_valid, output pcm_ready);
endinterface

// File: rtl/pdm_mic_decimator.sv
// Second-order CIC decimator turning a 1-bit PDM microphone stream into unsigned PCM.
// Optional macro PDM_DROP_CNT_EN adds the drop_cnt port counting overwritten samples.
module pdm_mic_decimator #(
   parameter int LOG2_DEC = 5
) (
   input  logic mclk,
   input  logic reset,
   input  logic pdm_in,
   input  logic enable,
   pdm_mic_decimator_if.master pcm,
`ifdef PDM_DROP_CNT_EN
   output logic [7:0] drop_cnt,
`endif
   output logic pcm_overflow
);
   localparam int OW = 2 * LOG2_DEC;
   localparam int R  = 1 << LOG2_DEC;
   localparam int IW = OW + 1;
   localparam logic [IW-1:0] FULL_SCALE = IW'(R * R);
   localparam logic [OW-1:0] MID_SCALE  = OW'(1 << (OW - 1));

   typedef enum logic [1:0] {WARM0, WARM1, RUN} state_t;

   state_t              state;
   logic [LOG2_DEC-1:0] phase;
   logic [IW-1:0]       i1, i2, i2_prev, c1_prev;
   logic [IW-1:0]       c1, c2;
   logic [OW-1:0]       sample;
   logic                strobe, load;

   // Full-scale R^2 is the only comb result needing OW+1 bits, so it clips to the top code.
   always_comb begin
      c1     = i2 - i2_prev;
      c2     = c1 - c1_prev;
      sample = (c2 == FULL_SCALE) ? {OW{1'b1}} : c2[OW-1:0];
      strobe = &phase;
      load   = strobe && (state == RUN);
   end

   always_ff @(posedge mclk) begin
      if (reset) begin
         state            <= WARM0;
         phase            <= '0;
         i1               <= '0;
         i2               <= '0;
         i2_prev          <= '0;
         c1_prev          <= '0;
         pcm.pcm_data     <= MID_SCALE;
         pcm.pcm_valid    <= 1'b0;
         pcm_overflow     <= 1'b0;
      end else if (!enable) begin
         state            <= WARM0;
         phase            <= '0;
         i1               <= '0;
         i2               <= '0;
         i2_prev          <= '0;
         c1_prev          <= '0;
         pcm.pcm_valid    <= 1'b0;
         pcm_overflow     <= 1'b0;
      end else begin
         phase <= phase + LOG2_DEC'(1);
         i1    <= i1 + IW'(pdm_in);
         i2    <= i2 + i1;
         // The first two frames only prime the comb history.
         if (strobe) begin
            i2_prev <= i2;
            c1_prev <= c1;
            case (state)
               WARM0:   state <= WARM1;
               WARM1:   state <= RUN;
               RUN:     state <= RUN;
               default: state <= WARM0;
            endcase
         end
         if (load) begin
            pcm.pcm_data  <= sample;
            pcm.pcm_valid <= 1'b1;
            if (pcm.pcm_valid && !pcm.pcm_ready)
               pcm_overflow <= 1'b1;
         end else if (pcm.pcm_valid && pcm.pcm_ready) begin
            pcm.pcm_valid <= 1'b0;
         end
      end
   end

`ifdef PDM_DROP_CNT_EN
   always_ff @(posedge mclk) begin
      if (reset || !enable)
         drop_cnt <= 8'd0;
      else if (load && pcm.pcm_valid && !pcm.pcm_ready && (drop_cnt != 8'hFF))
         drop_cnt <= drop_cnt + 8'd1;
   end
`endif
endmodule
